paddle_position_filter: RTL
===========================

# paddle_position_filter

Conditions one raw 8-bit potentiometer sample stream into a stable 10-bit paddle Y position for the pong game logic. It sits directly downstream of the potentiometer reader, one instance per player. It replaces the ad-hoc scale/deadzone/clamp arithmetic in the game FSM with:
- a pipelined moving average,
- fixed scaling,
- deadzone subtraction and range clamp,
- output hysteresis, so the paddle does not jitter on ADC noise.

## Interface
Parameters:
- AVG_LOG2, 2: log2 of moving-average window depth; legal 1..3, giving 2, 4 or 8 taps.
- DEADZONE, 41: offset subtracted after scaling; scaled values below it map to 0.
- MAX_POS, 430: upper clamp for pos. 480 display lines minus the 50-line paddle height.
- HYST, 3: minimum |new − current| that updates pos.

Ports:
- clk  in  1  system pixel clock (DIV_CLK[1] domain).
- reset  in  1  asynchronous, active-high; clears all state.
- sample_valid  in  1  one-cycle strobe; sample is valid this cycle.
- sample  in  8  raw potentiometer value, 0..255.
- pos  out  10  filtered paddle Y position, 0..MAX_POS.
- pos_valid  out  1  one-cycle strobe; one per accepted sample.
- pos_changed  out  1  one-cycle strobe, coincident with pos_valid, when pos took a new value.

## Operation
- Reset values:
  - pos = 0, pos_valid = 0, pos_changed = 0.
  - Window contents = 0, running sum = 0, primed flag = 0, pipeline valid bits = 0.
- Priming:
  - The first sample_valid after reset loads all 2^AVG_LOG2 window entries with that sample.
  - The sum is set to sample << AVG_LOG2, and primed is set.
  - There is no ramp from 0.
- Steady state: each sample_valid shifts sample into the window and drops the oldest entry.
  - sum ← sum + sample − oldest.
  - sum width is 8+AVG_LOG2 bits, unsigned; it never overflows.
- Stage 2 computes:
  - avg = sum >> AVG_LOG2 (8 bits).
  - scaled = {avg, 1'b0} (9 bits, 0..510).
- Stage 3 computes the candidate position:
  - cand = 0 if scaled < DEADZONE.
  - Otherwise d = scaled − DEADZONE (9 bits), and cand = MAX_POS if d > MAX_POS, else d.
- Hysteresis, evaluated in stage 3:
  - pos ← cand, and pos_changed = 1, if this is the first output since reset or |cand − pos| ≥ HYST.
  - Otherwise pos holds and pos_changed = 0.
  - pos_valid pulses in both cases.
- Back-to-back sample_valid on consecutive cycles is accepted. The pipeline is fully pipelined with throughput one sample per cycle and no stalls.
- The hysteresis compare always uses the registered pos. Back-to-back updates therefore compare against the most recently committed value.
- Reset mid-operation drops all in-flight samples, returns pos to 0, clears primed, and suppresses any pending pos_valid.

## Timing
- Latency: sample_valid high in cycle N gives pos_valid/pos_changed high in cycle N+3, with pos updated in that same cycle.
- Stage registers:
  - Window/sum at edge ending cycle N.
  - scaled at N+1.
  - pos at N+2 edge, visible in cycle N+3.
- The outputs are registered. There is no combinational path from sample to pos.
- pos is stable between pos_valid strobes. The consumer may sample pos on any cycle, including from the slower DIV_CLK[18] game FSM.

## Structure
- Shared package pong_pkg holds:
  - POS_W = 10.
  - PADDLE_H = 50.
  - SCREEN_H = 480.
  - Default DEADZONE and MAX_POS (derived as SCREEN_H − PADDLE_H).
  - A paddle position typedef (POS_W bits).
- One sub-module, sample_window, holds the shift register, priming and running-sum logic. It outputs sum plus a valid bit.
- The scale, deadzone, clamp and hysteresis logic stays in the top of the block.

## Test plan
All scenarios use default parameters.
- Reset, then sample 128 once. Required: pos_valid 3 cycles later, pos = 215 (256−41), pos_changed = 1. This exercises priming.
- Primed at 128, then sample 132. Required: avg 129, scaled 258, cand 217, diff 2 < 3, so pos stays 215, pos_valid = 1, pos_changed = 0.
- Primed at 100, then four samples of 200 back-to-back. Required: four pos_valid on consecutive cycles, with pos = 209, 259, 309, 359.
- Sample 0, then sample 255 (each primed after reset). Required: pos = 0 for the first. For the second, scaled 510, d 469, clamped to pos = 430.
- Sample 10 after reset. Required: scaled 20 < 41, so pos = 0, pos_valid = 1.
- Stream of 200 with reset asserted for 2 cycles mid-stream, one cycle after a sample_valid. Required:
  - pos = 0 immediately and no pos_valid for the dropped sample.
  - The next sample 50 re-primes and gives pos = 59.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants and types for the pong paddle path.
// POS_W        : width of a paddle Y position.
// PADDLE_H     : paddle height in display lines.
// SCREEN_H     : visible display lines.
// DEADZONE_DEF : default offset removed from the scaled pot reading.
// MAX_POS_DEF  : default top-of-paddle clamp (last line the paddle fits at).
package pong_pkg;

  localparam int unsigned POS_W        = 10;
  localparam int unsigned PADDLE_H     = 50;
  localparam int unsigned SCREEN_H     = 480;
  localparam int unsigned DEADZONE_DEF = 41;
  localparam int unsigned MAX_POS_DEF  = SCREEN_H - PADDLE_H;

  typedef logic [POS_W-1:0] pos_t;

endpackage

// File: rtl/sample_window.sv
// Moving-average window: shift register of the last 2^AVG_LOG2 samples plus a running sum.
// The first accepted sample after reset fills every tap so the average starts at that value.
// clk          : clock.
// reset        : asynchronous active-high reset.
// sample_valid : strobe qualifying sample.
// sample       : raw 8-bit pot value.
// sum          : registered sum of the window taps.
// sum_valid    : registered strobe, high the cycle after an accepted sample.
module sample_window #(
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [7:0]            sample,
  output logic [8+AVG_LOG2-1:0] sum,
  output logic                  sum_valid
);

  localparam int unsigned Depth = 1 << AVG_LOG2;
  localparam int unsigned SumW  = 8 + AVG_LOG2;

  logic [7:0]      win_q [Depth];
  logic [7:0]      win_d [Depth];
  logic [SumW-1:0] sum_q, sum_d;
  logic            primed_q, primed_d;
  logic            valid_q, valid_d;

  always_comb begin
    win_d    = win_q;
    sum_d    = sum_q;
    primed_d = primed_q;
    valid_d  = sample_valid;
    if (sample_valid) begin
      if (!primed_q) begin
        for (int i = 0; i < int'(Depth); i++) win_d[i] = sample;
        sum_d    = SumW'(sample) << AVG_LOG2;
        primed_d = 1'b1;
      end else begin
        win_d[0] = sample;
        for (int i = 1; i < int'(Depth); i++) win_d[i] = win_q[i-1];
        // Intermediate wrap is harmless: the true result always fits SumW bits.
        sum_d = sum_q + SumW'(sample) - SumW'(win_q[Depth-1]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) win_q[i] <= '0;
      sum_q    <= '0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      win_q    <= win_d;
      sum_q    <= sum_d;
      primed_q <= primed_d;
      valid_q  <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign sum_valid = valid_q;

endmodule

// File: rtl/paddle_position_filter.sv
// Turns a raw potentiometer sample stream into a stable paddle Y position.
// Pipeline: window/sum -> scale -> deadzone, clamp and hysteresis -> registered pos.
// clk          : pixel clock.
// reset        : asynchronous active-high reset, clears all state.
// sample_valid : one-cycle strobe qualifying sample.
// sample       : raw pot value 0..255.
// pos          : filtered paddle position 0..MAX_POS, stable between pos_valid strobes.
// pos_valid    : one strobe per accepted sample, three cycles after it.
// pos_changed  : coincident with pos_valid when pos took a new value.
module paddle_position_filter
  import pong_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned DEADZONE = DEADZONE_DEF,
  parameter int unsigned MAX_POS  = MAX_POS_DEF,
  parameter int unsigned HYST     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [7:0]       sample,
  output logic [POS_W-1:0] pos,
  output logic             pos_valid,
  output logic             pos_changed
);

  localparam logic [8:0] DzW   = 9'(DEADZONE);
  localparam pos_t       MaxP  = POS_W'(MAX_POS);
  localparam pos_t       HystW = POS_W'(HYST);

  logic [8+AVG_LOG2-1:0] win_sum;
  logic                  win_valid;

  sample_window #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_sample_window (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .sum          (win_sum),
    .sum_valid    (win_valid)
  );

  // Stage 2: average and fixed x2 scale.
  logic [8:0] scaled_q, scaled_d;
  logic       scaled_valid_q;

  always_comb begin
    scaled_d = {8'(win_sum >> AVG_LOG2), 1'b0};
  end

  // Stage 3: deadzone, clamp, hysteresis against the committed pos.
  pos_t       pos_q, pos_d;
  logic       pos_valid_q, pos_valid_d;
  logic       pos_changed_q, pos_changed_d;
  logic       seen_q, seen_d;  // at least one output since reset
  logic [8:0] d_off;
  pos_t       cand;
  pos_t       delta;
  logic       take;

  always_comb begin
    d_off = '0;
    cand  = '0;
    if (scaled_q >= DzW) begin
      d_off = scaled_q - DzW;
      cand  = (pos_t'(d_off) > MaxP) ? MaxP : pos_t'(d_off);
    end
    delta = (cand >= pos_q) ? (cand - pos_q) : (pos_q - cand);
    take  = !seen_q || (delta >= HystW);

    pos_d         = pos_q;
    pos_valid_d   = scaled_valid_q;
    pos_changed_d = 1'b0;
    seen_d        = seen_q;
    if (scaled_valid_q) begin
      seen_d        = 1'b1;
      pos_changed_d = take;
      if (take) pos_d = cand;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scaled_q       <= '0;
      scaled_valid_q <= 1'b0;
      pos_q          <= '0;
      pos_valid_q    <= 1'b0;
      pos_changed_q  <= 1'b0;
      seen_q         <= 1'b0;
    end else begin
      scaled_q       <= scaled_d;
      scaled_valid_q <= win_valid;
      pos_q          <= pos_d;
      pos_valid_q    <= pos_valid_d;
      pos_changed_q  <= pos_changed_d;
      seen_q         <= seen_d;
    end
  end

  assign pos         = pos_q;
  assign pos_valid   = pos_valid_q;
  assign pos_changed = pos_changed_q;

endmodule
